// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg -- shared definitions for the MEM stage load/store unit.
// Plays the role of the CPU-wide header: fixed bus widths (the register-index
// part is added by each module from its REG_ADDR_W parameter), the ld_op
// encodings and the ms_fwd_bus field order.
//
//   es_to_ms_bus : {mem_req, ld_op[2:0], gr_we, dest, alu_result[31:0], pc[31:0]}
//   ms_to_ws_bus : {gr_we, dest, final_result[31:0], pc[31:0]}
//   ms_fwd_bus   : {fwd_valid, fwd_ready, dest, final_result[31:0]}
package mem_stage_lsu_pkg;

    // Widths excluding the dest field.
    localparam int ES_FIXED_W  = 1 + 3 + 1 + 32 + 32;
    localparam int MS_FIXED_W  = 1 + 32 + 32;
    localparam int FWD_FIXED_W = 1 + 1 + 32;

    localparam logic [2:0] LD_LW  = 3'b000;
    localparam logic [2:0] LD_LB  = 3'b001;
    localparam logic [2:0] LD_LBU = 3'b010;
    localparam logic [2:0] LD_LH  = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// load_align -- combinational load data extraction.
// Configuration macro: MS_SUBWORD_LOAD_EN. When defined, byte/half loads are
// extracted and sign/zero extended; otherwise the word passes through
// untouched and ld_op/addr are ignored.
//
// Ports:
//   ld_op  in  3   load type (LD_* encodings)
//   addr   in  2   low address bits of the load
//   word   in  32  returned memory word
//   result out 32  value written back
module load_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [2:0]  ld_op,
    input  logic [1:0]  addr,
    input  logic [31:0] word,
    output logic [31:0] result
);

`ifdef MS_SUBWORD_LOAD_EN
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word[{addr, 3'b000} +: 8];
    assign half_sel = addr[1] ? word[31:16] : word[15:0];

    always_comb begin
        result = word;
        case (ld_op)
            LD_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  result = {24'h0, byte_sel};
            LD_LH:   result = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  result = {16'h0, half_sel};
            default: result = word;
        endcase
    end
`else
    logic unused_sel;
    assign unused_sel = ^{ld_op, addr};
    assign result     = word;
`endif

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu -- MEM pipeline stage: holds one instruction, waits for load
// data, aligns it and hands the result to WB; forwards to decode for bypass.
// Configuration macro: MS_SUBWORD_LOAD_EN (sub-word load extraction, see
// load_align).
//
// Ports:
//   clk, reset          clock, async active-high reset
//   ws_allowin          WB can accept
//   ms_allowin          MEM can accept
//   flush               cancel the instruction in MEM
//   es_to_ms_valid/bus  payload from EX
//   data_sram_data_ok   read data returned this cycle
//   data_sram_rdata     returned word
//   ms_to_ws_valid/bus  payload to WB
//   ms_fwd_bus          {fwd_valid, fwd_ready, dest, final_result}
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CANCEL_W   = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              ws_allowin,
    output logic                              ms_allowin,
    input  logic                              flush,
    input  logic                              es_to_ms_valid,
    input  logic [ES_FIXED_W+REG_ADDR_W-1:0]  es_to_ms_bus,
    input  logic                              data_sram_data_ok,
    input  logic [31:0]                       data_sram_rdata,
    output logic                              ms_to_ws_valid,
    output logic [MS_FIXED_W+REG_ADDR_W-1:0]  ms_to_ws_bus,
    output logic [FWD_FIXED_W+REG_ADDR_W-1:0] ms_fwd_bus
);

    logic                              ms_valid;
    logic                              ms_ready_go;
    logic [ES_FIXED_W+REG_ADDR_W-1:0]  payload;

    logic                  mem_req;
    logic [2:0]            ld_op;
    logic                  gr_we;
    logic [REG_ADDR_W-1:0] dest;
    logic [31:0]           alu_result;
    logic [31:0]           pc;

    logic                  buf_valid;
    logic [31:0]           buf_data;
    logic [CANCEL_W-1:0]   cancel_cnt;

    logic                  data_accept;
    logic                  discard;
    logic                  cancel_inc;
    logic [31:0]           load_word;
    logic [31:0]           load_result;
    logic [31:0]           final_result;

    assign {mem_req, ld_op, gr_we, dest, alu_result, pc} = payload;

    // data_ok belongs to the current load only once all stale responses from
    // earlier flushed loads have been drained.
    assign discard     = data_sram_data_ok && (cancel_cnt != '0);
    assign data_accept = ms_valid && mem_req && !buf_valid
                       && data_sram_data_ok && (cancel_cnt == '0);

    assign ms_ready_go    = !mem_req || buf_valid
                          || (data_sram_data_ok && (cancel_cnt == '0));
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;

    // A flushed load whose response is still in flight leaves one stale
    // data_ok behind. If its data_ok is arriving right now it dies here.
    assign cancel_inc = flush && ms_valid && mem_req && !buf_valid
                      && !(data_sram_data_ok && (cancel_cnt == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ms_valid <= 1'b0;
        else if (flush)
            ms_valid <= 1'b0;
        else if (ms_allowin)
            ms_valid <= es_to_ms_valid;
    end

    always_ff @(posedge clk) begin
        if (es_to_ms_valid && ms_allowin)
            payload <= es_to_ms_bus;
    end

    // Hold buffer: WB stalled on the cycle the data arrived.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            buf_valid <= 1'b0;
        else if (flush || (ms_valid && ms_ready_go && ws_allowin))
            buf_valid <= 1'b0;
        else if (data_accept && !ws_allowin)
            buf_valid <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (data_accept && !ws_allowin)
            buf_data <= data_sram_rdata;
    end

    // Simultaneous increment and decrement cancel out. Saturation is a
    // configuration error: the counter simply holds at its maximum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cancel_cnt <= '0;
        else if (cancel_inc && !discard && (cancel_cnt != '1))
            cancel_cnt <= cancel_cnt + 1'b1;
        else if (discard && !cancel_inc)
            cancel_cnt <= cancel_cnt - 1'b1;
    end

    assign load_word = buf_valid ? buf_data : data_sram_rdata;

    load_align u_load_align (
        .ld_op  (ld_op),
        .addr   (alu_result[1:0]),
        .word   (load_word),
        .result (load_result)
    );

    assign final_result = mem_req ? load_result : alu_result;

    assign ms_to_ws_bus = {gr_we, dest, final_result, pc};
    assign ms_fwd_bus   = {ms_valid && gr_we && (dest != '0), ms_ready_go,
                           dest, final_result};

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    localparam int RW = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        flush;
    logic        es_to_ms_valid;
    logic [73:0] es_to_ms_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [38:0] ms_fwd_bus;

    int checks = 0;
    int passed = 0;
    logic [69:0] sb[$];

    always #5 clk = ~clk;

    mem_stage_lsu #(.REG_ADDR_W(RW), .CANCEL_W(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .flush             (flush),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_fwd_bus        (ms_fwd_bus)
    );

    // Discard counter must never saturate in a correctly sized system.
    always @(posedge clk) begin
        if (!reset)
            assert (dut.cancel_cnt != 2'b11)
                else $error("FAIL cancel_cnt_saturated cnt=%0d", dut.cancel_cnt);
    end

    function automatic logic [73:0] mk_es(input logic mreq, input logic [2:0] op,
                                          input logic we, input logic [4:0] dst,
                                          input logic [31:0] alu, input logic [31:0] pc);
        return {mreq, op, we, dst, alu, pc};
    endfunction

    // Reference load extraction.
    function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [1:0] a,
                                             input logic [31:0] w);
`ifdef MS_SUBWORD_LOAD_EN
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0: b = w[7:0];
            2'd1: b = w[15:8];
            2'd2: b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (op)
            3'b001: return {{24{b[7]}}, b};
            3'b010: return {24'h0, b};
            3'b011: return {{16{h[15]}}, h};
            3'b100: return {16'h0, h};
            default: return w;
        endcase
`else
        return w;
`endif
    endfunction

    task automatic idle_inputs();
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        flush             = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        ws_allowin        = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1 || ms_fwd_bus[38] !== 1'b0)
            $display("FAIL reset_state: valid=%b allowin=%b fwd_valid=%b required 0/1/0",
                     ms_to_ws_valid, ms_allowin, ms_fwd_bus[38]);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_alu_pass();
        logic [69:0] exp;
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_es(1'b0, 3'b000, 1'b1, 5'd3, 32'h1234, 32'h100);
        sb.push_back({1'b1, 5'd3, 32'h1234, 32'h100});
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        #1;
        checks++;
        if (ms_to_ws_valid !== 1'b1)
            $display("FAIL alu_valid: got %b required 1", ms_to_ws_valid);
        else passed++;
        exp = sb.size() > 0 ? sb.pop_front() : 'x;
        checks++;
        if (ms_to_ws_bus !== exp)
            $display("FAIL alu_bus: got %h required %h", ms_to_ws_bus, exp);
        else passed++;
        checks++;
        if (ms_fwd_bus !== {1'b1, 1'b1, 5'd3, 32'h1234})
            $display("FAIL alu_fwd: got %h required %h", ms_fwd_bus,
                     {1'b1, 1'b1, 5'd3, 32'h1234});
        else passed++;
    endtask

    task automatic test_load(input logic [2:0] op, input logic [31:0] addr,
                             input logic [31:0] word, input int delay, input string name);
        logic [69:0] exp;
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_es(1'b1, op, 1'b1, 5'd7, addr, 32'h200);
        sb.push_back({1'b1, 5'd7, exp_load(op, addr[1:0], word), 32'h200});
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            es_to_ms_valid = 1'b0;
            #1;
            checks++;
            if (ms_allowin !== 1'b0 || ms_to_ws_valid !== 1'b0 || ms_fwd_bus[37] !== 1'b0)
                $display("FAIL %s_wait%0d: allowin=%b valid=%b fwd_ready=%b required 0/0/0",
                         name, i, ms_allowin, ms_to_ws_valid, ms_fwd_bus[37]);
            else passed++;
        end
        @(negedge clk);
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = word;
        #1;
        checks++;
        if (ms_to_ws_valid !== 1'b1)
            $display("FAIL %s_release: valid=%b required 1", name, ms_to_ws_valid);
        else passed++;
        exp = sb.size() > 0 ? sb.pop_front() : 'x;
        checks++;
        if (ms_to_ws_bus !== exp)
            $display("FAIL %s_bus: got %h required %h", name, ms_to_ws_bus, exp);
        else passed++;
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        #1;
        checks++;
        if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1)
            $display("FAIL %s_after: valid=%b allowin=%b required 0/1",
                     name, ms_to_ws_valid, ms_allowin);
        else passed++;
    endtask

    task automatic test_buffered();
        logic [69:0] exp;
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_es(1'b1, 3'b011, 1'b1, 5'd8, 32'h3002, 32'h300);
        sb.push_back({1'b1, 5'd8, exp_load(3'b011, 2'd2, 32'h8001_0000), 32'h300});
        @(negedge clk);
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h8001_0000;
        ws_allowin        = 1'b0;
        #1;
        checks++;
        if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b0)
            $display("FAIL buf_arrive: valid=%b allowin=%b required 1/0",
                     ms_to_ws_valid, ms_allowin);
        else passed++;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = 32'h1111_1111;
            #1;
            checks++;
            if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b0)
                $display("FAIL buf_hold%0d: valid=%b allowin=%b required 1/0",
                         i, ms_to_ws_valid, ms_allowin);
            else passed++;
        end
        @(negedge clk);
        ws_allowin = 1'b1;
        #1;
        exp = sb.size() > 0 ? sb.pop_front() : 'x;
        checks++;
        if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== exp)
            $display("FAIL buf_deliver: valid=%b bus=%h required 1/%h",
                     ms_to_ws_valid, ms_to_ws_bus, exp);
        else passed++;
        @(negedge clk);
        data_sram_rdata = 32'h0;
        #1;
        checks++;
        if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1)
            $display("FAIL buf_after: valid=%b allowin=%b required 0/1",
                     ms_to_ws_valid, ms_allowin);
        else passed++;
    endtask

    task automatic test_flush_cancel();
        logic [69:0] exp;
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_es(1'b1, 3'b000, 1'b1, 5'd4, 32'h4000, 32'h400);
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        flush          = 1'b1;
        #1;
        checks++;
        if (ms_to_ws_valid !== 1'b0)
            $display("FAIL fc_flush_valid: got %b required 0", ms_to_ws_valid);
        else passed++;
        @(negedge clk);
        flush          = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_es(1'b1, 3'b000, 1'b1, 5'd9, 32'h5000, 32'h500);
        sb.push_back({1'b1, 5'd9, 32'h1234_5678, 32'h500});
        #1;
        checks++;
        if (ms_allowin !== 1'b1 || dut.cancel_cnt !== 2'd1)
            $display("FAIL fc_cnt_up: allowin=%b cnt=%0d required 1/1",
                     ms_allowin, dut.cancel_cnt);
        else passed++;
        @(negedge clk);
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_DEAD;
        #1;
        checks++;
        if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b0)
            $display("FAIL fc_stale: valid=%b allowin=%b required 0/0",
                     ms_to_ws_valid, ms_allowin);
        else passed++;
        @(negedge clk);
        data_sram_rdata = 32'h1234_5678;
        #1;
        checks++;
        if (dut.cancel_cnt !== 2'd0 || ms_to_ws_valid !== 1'b1)
            $display("FAIL fc_new: cnt=%0d valid=%b required 0/1",
                     dut.cancel_cnt, ms_to_ws_valid);
        else passed++;
        exp = sb.size() > 0 ? sb.pop_front() : 'x;
        checks++;
        if (ms_to_ws_bus !== exp)
            $display("FAIL fc_bus: got %h required %h", ms_to_ws_bus, exp);
        else passed++;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_flush_coincide();
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_es(1'b1, 3'b000, 1'b1, 5'd5, 32'h6000, 32'h600);
        @(negedge clk);
        es_to_ms_valid    = 1'b0;
        flush             = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hAAAA_5555;
        #1;
        checks++;
        if (ms_to_ws_valid !== 1'b0)
            $display("FAIL coin_valid: got %b required 0", ms_to_ws_valid);
        else passed++;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (dut.cancel_cnt !== 2'd0 || ms_allowin !== 1'b1)
            $display("FAIL coin_cnt: cnt=%0d allowin=%b required 0/1",
                     dut.cancel_cnt, ms_allowin);
        else passed++;
    endtask

    task automatic test_inc_dec_same_cycle();
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_es(1'b1, 3'b000, 1'b0, 5'd0, 32'h7000, 32'h700);
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        flush          = 1'b1;
        @(negedge clk);
        flush          = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_es(1'b1, 3'b000, 1'b1, 5'd6, 32'h7100, 32'h710);
        @(negedge clk);
        es_to_ms_valid    = 1'b0;
        flush             = 1'b1;
        data_sram_data_ok = 1'b1;
        #1;
        checks++;
        if (ms_to_ws_valid !== 1'b0)
            $display("FAIL incdec_valid: got %b required 0", ms_to_ws_valid);
        else passed++;
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++;
        if (dut.cancel_cnt !== 2'd1 || ms_to_ws_valid !== 1'b0)
            $display("FAIL incdec_cnt: cnt=%0d valid=%b required 1/0",
                     dut.cancel_cnt, ms_to_ws_valid);
        else passed++;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (dut.cancel_cnt !== 2'd0 || ms_allowin !== 1'b1)
            $display("FAIL incdec_drain: cnt=%0d allowin=%b required 0/1",
                     dut.cancel_cnt, ms_allowin);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [69:0] exp;
        logic [4:0]  dsts [3] = '{5'd10, 5'd0, 5'd12};
        logic [4:0]  prev_dst;
        for (int i = 0; i <= 3; i++) begin
            @(negedge clk);
            if (i < 3) begin
                es_to_ms_valid = 1'b1;
                es_to_ms_bus   = mk_es(1'b0, 3'b000, 1'b1, dsts[i], 32'hA000 + i, 32'h800 + 4 * i);
                sb.push_back({1'b1, dsts[i], 32'hA000 + i, 32'h800 + 4 * i});
            end else begin
                es_to_ms_valid = 1'b0;
            end
            #1;
            if (i > 0) begin
                prev_dst = dsts[i-1];
                exp = sb.size() > 0 ? sb.pop_front() : 'x;
                checks++;
                if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== exp)
                    $display("FAIL b2b%0d: valid=%b bus=%h required 1/%h",
                             i - 1, ms_to_ws_valid, ms_to_ws_bus, exp);
                else passed++;
                checks++;
                if (ms_fwd_bus[38] !== (prev_dst != 5'd0))
                    $display("FAIL b2b_fwd%0d: fwd_valid=%b required %b",
                             i - 1, ms_fwd_bus[38], prev_dst != 5'd0);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_midwait();
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_es(1'b1, 3'b000, 1'b1, 5'd11, 32'h9000, 32'h900);
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1 || dut.cancel_cnt !== 2'd0)
            $display("FAIL reset_mid: valid=%b allowin=%b cnt=%0d required 0/1/0",
                     ms_to_ws_valid, ms_allowin, dut.cancel_cnt);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_alu_pass();
        test_load(3'b001, 32'h0000_1003, 32'h80FF_0000, 3, "lb");
        test_load(3'b100, 32'h0000_2002, 32'hBEEF_1234, 1, "lhu");
        test_load(3'b011, 32'h0000_2002, 32'hBEEF_1234, 1, "lh");
        test_load(3'b010, 32'h0000_2001, 32'h00A5_9C00, 2, "lbu");
        test_load(3'b000, 32'h0000_2000, 32'hCAFE_F00D, 1, "lw");
        test_buffered();
        test_flush_cancel();
        test_flush_coincide();
        test_inc_dec_same_cycle();
        test_back_to_back();
        test_reset_midwait();
        checks++;
        if (sb.size() != 0)
            $display("FAIL scoreboard_drain: %0d left required 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 The block SHALL have parameter REG_ADDR_W, default 5, giving the register-index width.
REQ-002 The block SHALL have parameter CANCEL_W, default 2, giving the width of the discard counter.
REQ-003 The block SHALL have the following ports, one per line (name, direction, width, meaning):
  clk  input  1  single clock; all state on its rising edge.
  reset  input  1  asynchronous, active-high reset.
  ws_allowin  input  1  WB stage can accept.
  ms_allowin  output  1  MEM stage can accept.
  flush  input  1  cancel the instruction in MEM (exception/redirect).
  es_to_ms_valid  input  1  EX payload valid.
  es_to_ms_bus  input  ES_TO_MS_BUS_WD  {mem_req, ld_op[2:0], gr_we, dest[REG_ADDR_W-1:0], alu_result[31:0], pc[31:0]}.
  data_sram_data_ok  input  1  read data returned this cycle.
  data_sram_rdata  input  32  returned word.
  ms_to_ws_valid  output  1  payload to WB valid.
  ms_to_ws_bus  output  MS_TO_WS_BUS_WD  {gr_we, dest, final_result[31:0], pc[31:0]}.
  ms_fwd_bus  output  REG_ADDR_W+34  {fwd_valid, fwd_ready, dest, final_result} for the decode-stage bypass.

Function
REQ-004 The payload register SHALL capture es_to_ms_bus on an edge with es_to_ms_valid && ms_allowin; ms_valid SHALL load es_to_ms_valid when ms_allowin, and SHALL be 0 after any edge with flush=1, regardless of the other inputs.
REQ-005 The block SHALL assert ms_allowin = !ms_valid || (ms_ready_go && ws_allowin), and ms_to_ws_valid = ms_valid && ms_ready_go && !flush.
REQ-006 ms_ready_go SHALL be 1 when mem_req=0; otherwise it SHALL be 1 when buf_valid=1 or when (data_sram_data_ok=1 && cancel_cnt=0).
REQ-007 A non-memory instruction SHALL pass through in 1 cycle; a load SHALL be forwarded combinationally in the same cycle as its accepted data_ok when ws_allowin=1.
REQ-008 When an accepted data_ok arrives while ws_allowin=0, the block SHALL capture rdata into a 32-bit hold buffer and set buf_valid; buf_valid SHALL clear when the instruction leaves MEM or is flushed.
REQ-009 Load extraction SHALL use ld_op and alu_result[1:0], with this encoding: 000 LW (whole word); 001 LB (sign-extended byte at bits [8*a+7:8*a]); 010 LBU (zero-extended byte); 011 LH (sign-extended half selected by a[1]); 100 LHU (zero-extended half); other codes behave as LW.
REQ-010 final_result SHALL be the extracted load data when mem_req=1, else alu_result.
REQ-011 If flush hits a valid load with mem_req=1 whose data has not yet been accepted, cancel_cnt SHALL increment by 1.
REQ-012 While cancel_cnt>0, each data_ok SHALL be discarded and SHALL decrement cancel_cnt.
REQ-013 A discard decrement and a flush increment in the same cycle SHALL leave cancel_cnt unchanged.
REQ-014 If flush and the current load's own data_ok coincide (cancel_cnt=0), the data SHALL be dropped without incrementing cancel_cnt.
REQ-015 cancel_cnt SHALL saturate at 2^CANCEL_W-1; reaching saturation is a configuration error, and the bench SHALL flag it with an assertion.
REQ-016 fwd_valid SHALL be ms_valid && gr_we && dest!=0; fwd_ready SHALL be ms_ready_go.

Reset
REQ-017 Asserting reset SHALL immediately force ms_valid=0, buf_valid=0 and cancel_cnt=0, so that ms_to_ws_valid=0, fwd_valid=0 and ms_allowin=1; payload and buffer contents SHALL be don't-care.
REQ-018 Reset asserted mid-load SHALL abandon the outstanding request; the memory side is reset by the same signal.

Configuration
REQ-019 The block SHALL recognise macro MS_SUBWORD_LOAD_EN.
REQ-020 With MS_SUBWORD_LOAD_EN defined, the block SHALL implement the extraction of REQ-009.
REQ-021 Without MS_SUBWORD_LOAD_EN, ld_op SHALL be ignored and the load result SHALL be the raw data_sram_rdata (or the buffered word); the bus layout SHALL be unchanged.

Structure
REQ-022 ES_TO_MS_BUS_WD, MS_TO_WS_BUS_WD, the ld_op encodings and the ms_fwd_bus field order SHALL live in the shared header mycpu.h.
REQ-023 Load extraction SHALL be a combinational sub-module, load_align (inputs: ld_op, addr[1:0], word; output: 32-bit result).

Verification
REQ-024 The bench SHALL cover these directed scenarios:
  ADD, alu_result=0x1234, ws_allowin=1 -> next cycle ms_to_ws_valid=1, final_result=0x1234.
  LB at addr 0x...3, rdata=0x80FF_0000, data_ok after 3 cycles -> final_result=0xFFFF_FF80, released the same cycle; ms_allowin=0 during the wait.
  LHU at addr 0x...2, rdata=0xBEEF_1234 -> 0x0000_BEEF; LH -> 0xFFFF_BEEF.
  Load data_ok while ws_allowin=0 for 2 cycles, rdata then changes -> the buffered value is delivered when ws_allowin=1.
  Flush a pending load, then a new load enters; the stale data_ok (0xDEAD) arrives first -> it is discarded, cancel_cnt 1->0, and the new load takes the second data_ok.
  Reset asserted mid-wait -> ms_to_ws_valid=0 and ms_allowin=1 immediately.
